// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: IF/ID state encoding, bubble word and reset vector.
package mips_pkg;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HOLD   = 2'd1,
        S_BUBBLE = 2'd2
    } ifid_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/ifid_perf_cnt.sv
// IF/ID performance counters: hold cycles, bubbles inserted, flush bubbles.
// Only instantiated by ifid_stage when IFID_PERF_CNT_EN is defined.
module ifid_perf_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold_evt,
    input  logic        bubble_evt,
    input  logic        flush_evt,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            bubble_count <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (hold_evt)   stall_cycles <= stall_cycles + 32'd1;
            if (bubble_evt) bubble_count <= bubble_count + 32'd1;
            if (flush_evt)  flush_count  <= flush_count + 32'd1;
        end
    end

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with flush/stall bubbles and an exception restart PC.
// Optional perf counters enabled by defining IFID_PERF_CNT_EN.
module ifid_stage #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IF_Flush,
    input  logic        IF_Stall,
    input  logic        ID_Stall,
    input  logic [31:0] IF_Instruction,
    input  logic [31:0] PCAdd4,
    input  logic [31:0] IF_PCOut,
    input  logic        IF_IsBDS,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PCAdd4,
    output logic [31:0] ID_PC,
    output logic        ID_IsBDS,
    output logic        ID_Valid,
    output logic        ID_IsFlushed,
    output logic [31:0] ID_RestartPC
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] ID_StallCycles,
    output logic [31:0] ID_BubbleCount,
    output logic [31:0] ID_FlushCount
`endif
);
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC4 = RESET_PC + 32'd4;

    ifid_state_t state;
    logic        do_flush;
    logic        do_hold;
    logic        do_bubble;
    logic [31:0] restart_next;

    always_comb begin
        do_flush     = IF_Flush;
        do_hold      = !IF_Flush && ID_Stall;
        do_bubble    = IF_Flush || (!ID_Stall && IF_Stall);
        // A delay-slot instruction restarts at its branch so the branch re-executes.
        restart_next = IF_IsBDS ? (IF_PCOut - 32'd4) : IF_PCOut;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ID_Instruction <= NOP_INSTR;
            ID_PC          <= RESET_PC;
            ID_PCAdd4      <= RESET_PC4;
            ID_RestartPC   <= RESET_PC;
            ID_IsBDS       <= 1'b0;
            ID_Valid       <= 1'b0;
            ID_IsFlushed   <= 1'b0;
            state          <= S_BUBBLE;
        end else if (do_hold) begin
            state <= S_HOLD;
        end else if (do_bubble) begin
            // PC and restart PC are kept so an interrupt on a bubble restarts at the last real instruction.
            ID_Instruction <= NOP_INSTR;
            ID_IsBDS       <= 1'b0;
            ID_Valid       <= 1'b0;
            ID_IsFlushed   <= do_flush;
            state          <= S_BUBBLE;
        end else begin
            ID_Instruction <= IF_Instruction;
            ID_PC          <= IF_PCOut;
            ID_PCAdd4      <= PCAdd4;
            ID_RestartPC   <= restart_next;
            ID_IsBDS       <= IF_IsBDS;
            ID_Valid       <= 1'b1;
            ID_IsFlushed   <= 1'b0;
            state          <= S_RUN;
        end
    end

`ifdef IFID_PERF_CNT_EN
    ifid_perf_cnt u_perf_cnt (
        .clock       (clock),
        .reset       (reset),
        .hold_evt    (do_hold),
        .bubble_evt  (do_bubble),
        .flush_evt   (do_flush),
        .stall_cycles(ID_StallCycles),
        .bubble_count(ID_BubbleCount),
        .flush_count (ID_FlushCount)
    );
`endif

    a_bubble_is_nop: assert property (@(posedge clock) disable iff (reset)
        !ID_Valid |-> (ID_Instruction == NOP_INSTR));
    a_flushed_not_valid: assert property (@(posedge clock) disable iff (reset)
        ID_IsFlushed |-> !ID_Valid);
    a_run_is_valid: assert property (@(posedge clock) disable iff (reset)
        (state == S_RUN) |-> ID_Valid);
    a_bubble_not_valid: assert property (@(posedge clock) disable iff (reset)
        (state == S_BUBBLE) |-> !ID_Valid);

endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
- IF/ID pipeline register. Receiving end of the IF-stage fetch bundle: flush, stall, instruction, PC+4, PC, branch-delay-slot flag.
- Registers the fetched instruction into the ID stage and inserts bubbles on flush or fetch stall.
- Holds its contents when ID stalls.
- Keeps an exception restart PC that stays valid across bubbles, for the exception unit.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word driven on a bubble (sll $0,$0,0).
- RESET_PC, 32'hBFC0_0000, reset value of ID_PC, ID_PCAdd4 (RESET_PC+4) and ID_RestartPC.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- IF_Flush  in  1  squash the fetched instruction (exception or branch-likely nullify).
- IF_Stall  in  1  fetch has no valid instruction this cycle (I-cache miss or AdIF pending).
- ID_Stall  in  1  ID stage cannot accept; hold all registers.
- IF_Instruction  in  32  fetched word.
- PCAdd4  in  32  fetch PC + 4.
- IF_PCOut  in  32  fetch PC.
- IF_IsBDS  in  1  fetched instruction is in a branch delay slot.
- ID_Instruction  out  32  registered instruction.
- ID_PCAdd4  out  32  registered PC+4.
- ID_PC  out  32  registered PC.
- ID_IsBDS  out  1  registered delay-slot flag.
- ID_Valid  out  1  ID holds a real instruction, not a bubble.
- ID_IsFlushed  out  1  current ID content is a flush bubble.
- ID_RestartPC  out  32  EPC candidate for the instruction in ID.

Behaviour:
- Reset (async, any time, including mid-stall): ID_Instruction=NOP_INSTR, ID_PC=RESET_PC, ID_PCAdd4=RESET_PC+4, ID_RestartPC=RESET_PC, ID_IsBDS=0, ID_Valid=0, ID_IsFlushed=0, state=S_BUBBLE.
- Per-edge priority (highest first):
  1. IF_Flush: bubble. ID_Instruction=NOP_INSTR, ID_IsBDS=0, ID_Valid=0, ID_IsFlushed=1, state=S_BUBBLE. ID_PC, ID_PCAdd4, ID_RestartPC hold. Flush overrides ID_Stall.
  2. ID_Stall: every register holds, ID_IsFlushed included; state=S_HOLD.
  3. IF_Stall: bubble as in (1) but ID_IsFlushed=0.
  4. Otherwise load. ID_Instruction=IF_Instruction, ID_PC=IF_PCOut, ID_PCAdd4=PCAdd4, ID_IsBDS=IF_IsBDS, ID_Valid=1, ID_IsFlushed=0, state=S_RUN.
- Restart PC:
  - Updates only on load: IF_IsBDS ? IF_PCOut-32'd4 : IF_PCOut, modulo 2^32 (wrap at 0 permitted).
  - Holds through bubbles and holds, so an interrupt taken on a bubble restarts at the last real instruction.
- Latency: exactly 1 cycle from IF inputs to ID outputs on load.
- State machine: S_RUN (last edge loaded), S_HOLD (last edge held), S_BUBBLE (last edge inserted a bubble).
  - Transitions follow the priority above.
  - Outputs are registered and independent of state; state exists for the perf counters and assertions.
- Simultaneous IF_Flush and IF_Stall: flush bubble, ID_IsFlushed=1.
- ID_Stall released: the next edge applies normal priority. No instruction is lost, because IF holds PC while ID_Stall is high.
- Assertions:
  - ID_Valid=0 implies ID_Instruction==NOP_INSTR.
  - ID_IsFlushed=1 implies ID_Valid=0.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined:
  - Three 32-bit output counters: ID_StallCycles (+1 per edge in S_HOLD), ID_BubbleCount (+1 per bubble insertion), ID_FlushCount (+1 per IF_Flush bubble).
  - All wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - typedef enum logic [1:0] ifid_state_t {S_RUN, S_HOLD, S_BUBBLE}.
  - NOP_INSTR constant.
  - RESET_VECTOR constant.
- Sub-module ifid_perf_cnt holds the three counters under the macro; instantiated only when IFID_PERF_CNT_EN is defined.

Test Plan:
- Reset asserted mid-cycle with ID_Valid=1 -> outputs go to reset values immediately, without waiting for a clock edge; ID_PC=32'hBFC0_0000.
- Load IF_PCOut=32'h0040_0010, PCAdd4=32'h0040_0014, IF_Instruction=32'h2408_0005, IF_IsBDS=0 -> next cycle ID_Valid=1, ID_RestartPC=32'h0040_0010.
- Load with IF_IsBDS=1, IF_PCOut=32'h0040_0024, then IF_Stall for 2 cycles -> ID_Instruction=0, ID_Valid=0, ID_RestartPC stays 32'h0040_0020.
- ID_Stall high for 3 cycles while IF inputs change -> ID outputs frozen; with the macro, ID_StallCycles=3.
- IF_Flush and ID_Stall high together -> bubble with ID_IsFlushed=1; ID_FlushCount increments by 1.
- IF_PCOut=32'h0000_0000 with IF_IsBDS=1 -> ID_RestartPC=32'hFFFF_FFFC (wrap).
